pio_input_conditioner: RTL

//  Producer side of the SoC PIO inputs: takes raw board switches and the active-low

---
 rtl/pio_cond_pkg.sv | 9 +
 rtl/input_debouncer.sv | 53 +++++
 rtl/pio_input_conditioner.sv | 68 ++++++
 3 files changed

// File: rtl/pio_cond_pkg.sv
// Shared constants for the PIO input conditioner: debounce default, press counter width, key polarity.
package pio_cond_pkg;

  localparam int unsigned DEBOUNCE_10MS_50MHZ = 500000;
  localparam int unsigned PRESS_CNT_W         = 8;
  localparam logic        KEY_PRESSED         = 1'b0;
  localparam logic        KEY_RELEASED        = 1'b1;

endpackage

// File: rtl/input_debouncer.sv
// One-bit 2-flop synchroniser followed by a stable-count debounce filter.
module input_debouncer
  import pio_cond_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_10MS_50MHZ,
  parameter logic        RESET_VAL       = 1'b0
) (
  input  logic clk_clk,
  input  logic reset_reset_n,
  input  logic raw,
  output logic clean
);

  localparam int unsigned          CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]     CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      s1_q     <= RESET_VAL;
      s2_q     <= RESET_VAL;
      stable_q <= RESET_VAL;
      cnt_q    <= '0;
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  // Any sample that agrees with the accepted level restarts the stability count.
  always_comb begin
    s1_d     = raw;
    s2_d     = s1_q;
    stable_d = stable_q;
    cnt_d    = '0;
    if (s2_q != stable_q) begin
      if (cnt_q == CNT_MAX) begin
        stable_d = s2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  assign clean = stable_q;

endmodule

// File: rtl/pio_input_conditioner.sv
// Debounces board switches and the accumulate key for the SoC PIOs; adds a press strobe and counter.
module pio_input_conditioner
  import pio_cond_pkg::*;
#(
  parameter int unsigned SW_W            = 8,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_10MS_50MHZ
) (
  input  logic                   clk_clk,
  input  logic                   reset_reset_n,
  input  logic [SW_W-1:0]        sw_raw,
  input  logic                   key_raw_n,
  output logic [SW_W-1:0]        switch_wire_export,
  output logic                   accumulate_button_export,
  output logic                   accumulate_press_pulse,
  output logic [PRESS_CNT_W-1:0] press_count
);

  logic                   btn_prev_q, btn_prev_d;
  logic                   pulse_q, pulse_d;
  logic [PRESS_CNT_W-1:0] press_count_q, press_count_d;
  logic                   fall_c;

  for (genvar i = 0; i < int'(SW_W); i++) begin : g_sw
    input_debouncer #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RESET_VAL       (1'b0)
    ) u_sw_db (
      .clk_clk       (clk_clk),
      .reset_reset_n (reset_reset_n),
      .raw           (sw_raw[i]),
      .clean         (switch_wire_export[i])
    );
  end

  input_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .RESET_VAL       (KEY_RELEASED)
  ) u_key_db (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .raw           (key_raw_n),
    .clean         (accumulate_button_export)
  );

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      btn_prev_q    <= KEY_RELEASED;
      pulse_q       <= 1'b0;
      press_count_q <= '0;
    end else begin
      btn_prev_q    <= btn_prev_d;
      pulse_q       <= pulse_d;
      press_count_q <= press_count_d;
    end
  end

  // Only the released-to-pressed transition of the debounced key is a press.
  always_comb begin
    fall_c        = (btn_prev_q == KEY_RELEASED) && (accumulate_button_export == KEY_PRESSED);
    btn_prev_d    = accumulate_button_export;
    pulse_d       = fall_c;
    press_count_d = press_count_q + PRESS_CNT_W'(fall_c);
  end

  assign accumulate_press_pulse = pulse_q;
  assign press_count            = press_count_q;

endmodule
